// File: rtl/sram_ctrl_pkg.sv
// Shared types and default sizing for the SRAM front-end controller.
// The state encodings are fixed at 2 bits so that other blocks can decode them.
package sram_ctrl_pkg;

  localparam int BW_DATA_DEF = 64;
  localparam int BW_ADDR_DEF = 6;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RSP     = 2'd3
  } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: clears the whole memory after reset, then serves
// single-cycle writes and 2-cycle reads with at most one read outstanding.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | write zero to every word, one address per cycle
// IDLE     | accept a request; a write completes in the same cycle
// RD_WAIT  | memory returns read data; it is captured into o_rsp_rdata
// RSP      | hold o_rsp_valid/o_rsp_rdata until the consumer takes them
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BW_DATA = BW_DATA_DEF,
  parameter int BW_ADDR = BW_ADDR_DEF
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [BW_ADDR-1:0] i_req_addr,
  input  logic [BW_DATA-1:0] i_req_wdata,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [BW_DATA-1:0] o_rsp_rdata,
  output logic               o_init_done,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  input  logic [BW_DATA-1:0] i_mem_data
);

  state_t           state;
  state_t           state_nxt;
  logic [BW_ADDR:0] init_cnt;
  logic             init_last;

  // One spare counter bit; the counter parks on the last address instead of wrapping.
  assign init_last = (init_cnt == {1'b0, {BW_ADDR{1'b1}}});

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      o_init_done <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        if (init_last) o_init_done <= 1'b1;
        else           init_cnt    <= init_cnt + {{BW_ADDR{1'b0}}, 1'b1};
      end
      if (state == ST_RD_WAIT) o_rsp_rdata <= i_mem_data;
    end
  end

  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_oen   = 1'b0;
    o_mem_addr  = i_req_addr;
    o_mem_data  = i_req_wdata;
    case (state)
      ST_INIT: begin
        // State already sits in INIT during reset, so gate the strobe with reset.
        o_mem_wen  = i_rstn;
        o_mem_addr = init_cnt[BW_ADDR-1:0];
        o_mem_data = '0;
        if (init_last) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (i_req_we) begin
            o_mem_wen = 1'b1;
          end else begin
            o_mem_oen = 1'b1;
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        state_nxt = ST_RSP;
      end
      ST_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Param BW_DATA, default 64, data word width; SHALL match memory data width.
REQ-002 Param BW_ADDR, default 6, word address width (64 words).
REQ-003 i_clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 i_rstn  in  1  asynchronous, active-low reset.
REQ-005 i_req_valid  in  1  request valid.
REQ-006 o_req_ready  out  1  controller accepts request this cycle.
REQ-007 i_req_we  in  1  1 = write, 0 = read.
REQ-008 i_req_addr  in  BW_ADDR  word address.
REQ-009 i_req_wdata  in  BW_DATA  write data.
REQ-010 o_rsp_valid  out  1  read data valid.
REQ-011 i_rsp_ready  in  1  consumer accepts read data.
REQ-012 o_rsp_rdata  out  BW_DATA  read data, held stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-013 o_init_done  out  1  post-reset memory clear finished.
REQ-014 o_mem_addr  out  BW_ADDR  memory address.
REQ-015 o_mem_data  out  BW_DATA  memory write data.
REQ-016 o_mem_wen  out  1  1 = write strobe this cycle.
REQ-017 o_mem_oen  out  1  1 = read enable this cycle.
REQ-018 i_mem_data  in  BW_DATA  memory read data, valid exactly 1 cycle after the o_mem_oen=1 cycle.

Function
REQ-019 FSM states SHALL be INIT, IDLE, RD_WAIT, RSP.
REQ-020 INIT: write zero to address 0..2^BW_ADDR-1, one per cycle (o_mem_wen=1, o_mem_data=0); after address 63 -> IDLE and o_init_done=1 (sticky until reset).
REQ-021 o_req_ready SHALL be 1 only in IDLE; handshake = i_req_valid & o_req_ready.
REQ-022 Write handshake: same cycle o_mem_wen=1, o_mem_addr=i_req_addr, o_mem_data=i_req_wdata (combinational); state stays IDLE; back-to-back writes one per cycle.
REQ-023 Read handshake: same cycle o_mem_oen=1, o_mem_addr=i_req_addr; -> RD_WAIT.
REQ-024 RD_WAIT: capture i_mem_data into o_rsp_rdata register; -> RSP next cycle with o_rsp_valid=1.
REQ-025 Read latency: request handshake at cycle N -> o_rsp_valid=1 at N+2.
REQ-026 RSP: hold o_rsp_valid/o_rsp_rdata until i_rsp_ready=1, then -> IDLE; o_req_ready=0 throughout (one outstanding read max).
REQ-027 o_mem_wen and o_mem_oen SHALL never both be 1; both 0 in RD_WAIT, RSP, and IDLE without handshake.
REQ-028 Requests arriving during INIT SHALL be stalled (o_req_ready=0), not dropped.
REQ-029 Address counter SHALL be BW_ADDR+1 bits internally; terminal detect on count==2^BW_ADDR-1, no wrap into address 0.

Reset
REQ-030 On i_rstn=0 (async): state=INIT, init counter=0, o_init_done=0, o_rsp_valid=0, o_rsp_rdata=0.
REQ-031 Reset mid-INIT or mid-read SHALL abort the operation; INIT restarts from address 0 after release; pending response discarded.
REQ-032 Outputs o_req_ready, o_mem_wen, o_mem_oen SHALL be 0 while i_rstn=0.

Structure
REQ-033 State encodings (2-bit) and default BW_DATA/BW_ADDR SHALL live in shared package/header sram_ctrl_pkg.
REQ-034 Single flat module; no sub-module; instantiated directly upstream of the 64x64 banked SRAM.

Verification
REQ-035 Reset release -> 64 consecutive o_mem_wen=1 cycles, addr 0..63, data 0; o_init_done=1 on cycle 65; o_req_ready=1.
REQ-036 Write 0xDEADBEEF_01234567 @ addr 0x2A, then read 0x2A -> o_rsp_rdata=0xDEADBEEF_01234567, o_rsp_valid 2 cycles after read handshake.
REQ-037 Read with i_rsp_ready=0 for 5 cycles -> o_rsp_valid and data stable, o_req_ready=0; release -> IDLE next cycle.
REQ-038 Writes to addr 0x00, 0x0F, 0x10, 0x3F back-to-back (4 cycles) then reads -> each returns own data (bank boundaries intact); unwritten addr 0x11 returns 0.
REQ-039 Assert i_rstn=0 at INIT address 20 -> after release INIT restarts at 0, full 64 writes, o_init_done=0 until done.
REQ-040 Random write/read traffic vs reference model, 10k requests -> no mismatch, wen/oen never concurrent.
